// File: rtl/ace_master_port.sv
// ACE master port: turns single-line ReadShared / CleanUnique / WriteBack requests
// from the cache controller into AR/R and AW/W/B handshakes, one transaction at a time.
module ace_master_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic                  invalid_req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] wb_data,
  output logic                  ace_ready,
  output logic [LINE_WIDTH-1:0] fill_data,
  output logic                  fill_shared,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [3:0]            arsnoop,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [LINE_WIDTH-1:0] rdata,
  input  logic [3:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awsnoop,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [LINE_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  rack,
  output logic                  wack
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE} state_t;
  typedef enum logic [1:0] {OP_READ, OP_INVAL, OP_WRITE} op_t;

  localparam logic [3:0] SNOOP_READ_SHARED  = 4'b0001;
  localparam logic [3:0] SNOOP_CLEAN_UNIQUE = 4'b1011;
  localparam logic [2:0] SNOOP_WRITE_BACK   = 3'b011;

  state_t state;
  op_t    op;
  logic   aw_done;
  logic   w_done;
  logic   aw_fire;
  logic   w_fire;
  logic   any_req;

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign any_req = write_req | invalid_req | read_req;

  // Only IsShared and the error bit of the responses carry meaning for this port.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{rresp[2], rresp[0], bresp[0]};

  // NOTE: every handshake output is a flop set on the state transition, so no
  // valid ever depends combinationally on its ready.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the datapath registers are reset too, so addresses and fill data
    // read as zero straight out of reset rather than as stale contents.
    if (!reset) begin
      state       <= IDLE;
      op          <= OP_READ;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      arvalid     <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      rready      <= 1'b0;
      bready      <= 1'b0;
      ace_ready   <= 1'b0;
      rack        <= 1'b0;
      wack        <= 1'b0;
      resp_err    <= 1'b0;
      fill_shared <= 1'b0;
      fill_data   <= '0;
      araddr      <= '0;
      awaddr      <= '0;
      wdata       <= '0;
      arsnoop     <= '0;
      awsnoop     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values and the default pulse clears below are overridable.
      ace_ready <= 1'b0;
      rack      <= 1'b0;
      wack      <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (any_req) begin
            araddr <= req_addr;
            awaddr <= req_addr;
            wdata  <= wb_data;
          end
          // Writes win; any lower-priority request raised in the same cycle is dropped.
          if (write_req) begin
            op      <= OP_WRITE;
            awsnoop <= SNOOP_WRITE_BACK;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_ADDR_DATA;
          end else if (invalid_req) begin
            op      <= OP_INVAL;
            arsnoop <= SNOOP_CLEAN_UNIQUE;
            arvalid <= 1'b1;
            state   <= RD_ADDR;
          end else if (read_req) begin
            op      <= OP_READ;
            arsnoop <= SNOOP_READ_SHARED;
            arvalid <= 1'b1;
            state   <= RD_ADDR;
          end else begin
            state <= IDLE;
          end
        end

        RD_ADDR: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (rvalid) begin
            // CleanUnique carries no data, so the previous fill stays visible.
            if (op == OP_READ) begin
              fill_data   <= rdata;
              fill_shared <= rresp[3];
            end
            resp_err  <= rresp[1];
            rready    <= 1'b0;
            ace_ready <= 1'b1;
            rack      <= 1'b1;
            state     <= DONE;
          end
        end

        WR_ADDR_DATA: begin
          if (aw_fire) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            resp_err  <= bresp[1];
            bready    <= 1'b0;
            ace_ready <= 1'b1;
            wack      <= 1'b1;
            state     <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ace_master_port.sv
// Scoreboard bench for ace_master_port: directed corner cases plus randomized
// transactions against a transaction-level model of the port and its slave.
module tb_ace_master_port;

  localparam int AW = 32;
  localparam int LW = 128;

  typedef enum {K_READ, K_INVAL, K_WRITE} kind_t;

  typedef struct {
    kind_t          kind;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  data;
    logic [LW-1:0]  fill;
    logic           shared;
    logic           err;
  } exp_t;

  typedef struct {
    logic [LW-1:0] rdata;
    logic [3:0]    rresp;
    logic [1:0]    bresp;
    int            ar_stall;
    int            r_delay;
    int            aw_stall;
    int            w_stall;
    int            b_delay;
  } slv_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          read_req, write_req, invalid_req;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] wb_data;
  logic          ace_ready;
  logic [LW-1:0] fill_data;
  logic          fill_shared, resp_err;
  logic [AW-1:0] araddr;
  logic [3:0]    arsnoop;
  logic          arvalid, arready;
  logic [LW-1:0] rdata;
  logic [3:0]    rresp;
  logic          rvalid, rready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awsnoop;
  logic          awvalid, awready;
  logic [LW-1:0] wdata;
  logic          wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic          rack, wack;
  logic          slv_bvalid;
  logic          glitch_b;

  assign bvalid = slv_bvalid | glitch_b;

  always #5 clk = ~clk;

  ace_master_port #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .req_addr(req_addr), .wb_data(wb_data),
    .ace_ready(ace_ready), .fill_data(fill_data), .fill_shared(fill_shared), .resp_err(resp_err),
    .araddr(araddr), .arsnoop(arsnoop), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsnoop(awsnoop), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rack(rack), .wack(wack)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  slv_t cur;
  logic slave_flush;

  // Reference model of the consumer-visible result registers.
  logic [LW-1:0] m_fill;
  logic          m_shared;
  logic          m_err;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic kind_t pick_kind(bit wr, bit inv);
    return wr ? K_WRITE : (inv ? K_INVAL : K_READ);
  endfunction

  task automatic zero_cfg();
    cur.ar_stall = 0; cur.r_delay = 0; cur.aw_stall = 0; cur.w_stall = 0; cur.b_delay = 0;
    cur.rdata = rand_line(); cur.rresp = 4'($urandom()); cur.bresp = 2'($urandom());
  endtask

  task automatic rand_cfg();
    cur.rdata    = rand_line();
    cur.rresp    = 4'($urandom());
    cur.bresp    = 2'($urandom());
    cur.ar_stall = int'($urandom_range(0, 3));
    cur.r_delay  = int'($urandom_range(0, 3));
    cur.aw_stall = int'($urandom_range(0, 3));
    cur.w_stall  = int'($urandom_range(0, 3));
    cur.b_delay  = int'($urandom_range(0, 3));
  endtask

  // Push the completion the port must report, and advance the model.
  task automatic push_exp(kind_t k, logic [AW-1:0] a, logic [LW-1:0] d);
    exp_t e;
    case (k)
      K_READ: begin
        m_fill   = cur.rdata;
        m_shared = cur.rresp[3];
        m_err    = cur.rresp[1];
      end
      K_INVAL: m_err = cur.rresp[1];
      default: m_err = cur.bresp[1];
    endcase
    e.kind = k; e.addr = a; e.data = d;
    e.fill = m_fill; e.shared = m_shared; e.err = m_err;
    exp_q.push_back(e);
  endtask

  // Called one step after a rising edge with the port in IDLE or DONE.
  task automatic start_req(bit wr, bit inv, bit rd, logic [AW-1:0] a, logic [LW-1:0] d);
    write_req = wr; invalid_req = inv; read_req = rd; req_addr = a; wb_data = d;
    if (wr || inv || rd) push_exp(pick_kind(wr, inv), a, d);
    @(posedge clk); #1;
    write_req = 1'b0; invalid_req = 1'b0; read_req = 1'b0;
  endtask

  // Cycles from the request cycle to the ace_ready cycle.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!ace_ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ace_ready) check("done_timeout", 256'(ace_ready), 256'(1));
  endtask

  // Slave model: per-transaction stalls from cur; handshakes observed on the falling edge.
  bit r_pend, b_pend, aw_seen, w_seen;
  int r_cnt, b_cnt, ar_cnt, aw_cnt, w_cnt;

  initial begin : slave
    bit hs_ar, hs_r, hs_aw, hs_w, hs_b;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; slv_bvalid = 1'b0; rdata = '0; rresp = '0; bresp = '0;
    forever begin
      @(negedge clk);
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_b  = bvalid && bready;
      @(posedge clk); #1;
      if (slave_flush) begin
        rvalid = 1'b0; slv_bvalid = 1'b0;
        r_pend = 1'b0; b_pend = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
      end else begin
        if (hs_ar) begin r_pend = 1'b1; r_cnt = 0; end
        if (hs_r) rvalid = 1'b0;
        if (r_pend) begin
          if (r_cnt >= cur.r_delay) begin
            rvalid = 1'b1; rdata = cur.rdata; rresp = cur.rresp; r_pend = 1'b0;
          end else r_cnt++;
        end
        if (hs_aw) aw_seen = 1'b1;
        if (hs_w)  w_seen  = 1'b1;
        if (aw_seen && w_seen) begin
          b_pend = 1'b1; b_cnt = 0; aw_seen = 1'b0; w_seen = 1'b0;
        end
        if (hs_b) slv_bvalid = 1'b0;
        if (b_pend) begin
          if (b_cnt >= cur.b_delay) begin
            slv_bvalid = 1'b1; bresp = cur.bresp; b_pend = 1'b0;
          end else b_cnt++;
        end
      end
      if (arvalid) begin
        if (ar_cnt >= cur.ar_stall) arready = 1'b1; else begin arready = 1'b0; ar_cnt++; end
      end else begin arready = 1'b0; ar_cnt = 0; end
      if (awvalid) begin
        if (aw_cnt >= cur.aw_stall) awready = 1'b1; else begin awready = 1'b0; aw_cnt++; end
      end else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin
        if (w_cnt >= cur.w_stall) wready = 1'b1; else begin wready = 1'b0; w_cnt++; end
      end else begin wready = 1'b0; w_cnt = 0; end
    end
  end

  initial begin : monitor
    exp_t          e;
    bit            p_ar, p_aw, p_w;
    logic [AW-1:0] pa_ar, pa_aw;
    logic [3:0]    ps_ar;
    logic [2:0]    ps_aw;
    logic [LW-1:0] pd_w;
    p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0;
        continue;
      end
      if (p_ar) check("ar_hold", 256'({arvalid, arsnoop, araddr}), 256'({1'b1, ps_ar, pa_ar}));
      if (p_aw) check("aw_hold", 256'({awvalid, awsnoop, awaddr}), 256'({1'b1, ps_aw, pa_aw}));
      if (p_w)  check("w_hold",  256'({wvalid, wdata}), 256'({1'b1, pd_w}));
      p_ar = arvalid && !arready; pa_ar = araddr; ps_ar = arsnoop;
      p_aw = awvalid && !awready; pa_aw = awaddr; ps_aw = awsnoop;
      p_w  = wvalid && !wready;   pd_w  = wdata;

      if (arvalid && arready) begin
        if (exp_q.size() == 0) check("ar_unexpected", 256'(arvalid), 256'(0));
        else begin
          e = exp_q[0];
          if (e.kind == K_WRITE) check("ar_for_write", 256'(arvalid), 256'(0));
          else begin
            check("ar_addr", 256'(araddr), 256'(e.addr));
            check("ar_snoop", 256'(arsnoop), 256'((e.kind == K_INVAL) ? 4'b1011 : 4'b0001));
          end
        end
      end
      if (awvalid && awready) begin
        if (exp_q.size() == 0 || exp_q[0].kind != K_WRITE) check("aw_unexpected", 256'(awvalid), 256'(0));
        else check("aw_addr_snoop", 256'({awsnoop, awaddr}), 256'({3'b011, exp_q[0].addr}));
      end
      if (wvalid && wready) begin
        if (exp_q.size() == 0 || exp_q[0].kind != K_WRITE) check("w_unexpected", 256'(wvalid), 256'(0));
        else check("w_data", 256'(wdata), 256'(exp_q[0].data));
      end
      if (ace_ready) begin
        if (exp_q.size() == 0) check("ace_ready_unexpected", 256'(ace_ready), 256'(0));
        else begin
          e = exp_q.pop_front();
          check("ack_kind", 256'({rack, wack}), 256'((e.kind == K_WRITE) ? 2'b01 : 2'b10));
          check("fill_data", 256'(fill_data), 256'(e.fill));
          check("fill_shared_err", 256'({fill_shared, resp_err}), 256'({e.shared, e.err}));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    reset = 1'b1; slave_flush = 1'b0; glitch_b = 1'b0;
    read_req = 1'b0; write_req = 1'b0; invalid_req = 1'b0;
    req_addr = '0; wb_data = '0;
    m_fill = '0; m_shared = 1'b0; m_err = 1'b0;
    zero_cfg();

    #2 reset = 1'b0;
    #1;
    check("reset_ctrl", 256'({arvalid, awvalid, wvalid, rready, bready, ace_ready, rack, wack,
                              resp_err, fill_shared}), 256'(0));
    check("reset_data", 256'({fill_data, wdata}), 256'(0));
    check("reset_addr", 256'({araddr, awaddr, arsnoop, awsnoop}), 256'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // ReadShared with an always-ready slave.
    zero_cfg(); cur.rdata = {16{8'hA5}}; cur.rresp = 4'b1000;
    start_req(1'b0, 1'b0, 1'b1, 32'h0000_1000, '0);
    check("rd_arvalid_n1", 256'(arvalid), 256'(1));
    wait_done(lat);
    check("rd_latency", 256'(lat), 256'(3));
    @(posedge clk); #1;

    // WriteBack with AW stalled three cycles.
    zero_cfg(); cur.aw_stall = 3; cur.bresp = 2'b00;
    start_req(1'b1, 1'b0, 1'b0, 32'h0000_2000, 128'h1234);
    wait_done(lat);
    check("wr_stall_latency", 256'(lat), 256'(6));
    @(posedge clk); #1;

    // CleanUnique with an error response; fill stays at the previous read.
    zero_cfg(); cur.rresp = 4'b0010;
    start_req(1'b0, 1'b1, 1'b0, 32'h0000_3000, '0);
    wait_done(lat);
    check("inval_latency", 256'(lat), 256'(3));
    @(posedge clk); #1;

    // Write and read together: write wins, the held read starts in DONE.
    zero_cfg();
    start_req(1'b1, 1'b0, 1'b1, 32'h0000_4000, rand_line());
    read_req = 1'b1; req_addr = 32'h0000_4040;
    push_exp(K_READ, 32'h0000_4040, '0);
    wait_done(lat);
    check("prio_wr_latency", 256'(lat), 256'(3));
    @(posedge clk); #1;
    check("held_read_arvalid", 256'(arvalid), 256'(1));
    read_req = 1'b0;
    wait_done(lat);
    check("held_read_latency", 256'(lat), 256'(3));
    @(posedge clk); #1;

    // Stray bvalid while idle.
    glitch_b = 1'b1;
    @(negedge clk);
    check("glitch_b_idle", 256'({bready, ace_ready, wack}), 256'(0));
    @(posedge clk); #1;
    glitch_b = 1'b0;
    check("glitch_b_after", 256'({bready, ace_ready, arvalid, awvalid}), 256'(0));
    zero_cfg();
    start_req(1'b0, 1'b0, 1'b1, 32'h0000_5000, '0);
    wait_done(lat);
    check("after_glitch_latency", 256'(lat), 256'(3));
    @(posedge clk); #1;

    // Reset while waiting for read data.
    zero_cfg(); cur.r_delay = 6;
    start_req(1'b0, 1'b0, 1'b1, 32'h0000_6000, '0);
    for (int i = 0; i < 10 && !rready; i++) begin @(posedge clk); #1; end
    check("rd_data_reached", 256'(rready), 256'(1));
    #2 reset = 1'b0;
    #1;
    check("midreset_ctrl", 256'({arvalid, awvalid, wvalid, rready, bready, ace_ready, rack, wack,
                                 resp_err, fill_shared}), 256'(0));
    check("midreset_data", 256'({fill_data, araddr, arsnoop}), 256'(0));
    exp_q.delete();
    m_fill = '0; m_shared = 1'b0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("post_reset_rvalid_ignored", 256'({rready, ace_ready, rack}), 256'(0));
    end
    @(negedge clk); slave_flush = 1'b1;
    @(negedge clk); @(negedge clk); slave_flush = 1'b0;
    @(posedge clk); #1;
    zero_cfg();
    start_req(1'b0, 1'b1, 1'b0, 32'h0000_7000, '0);
    wait_done(lat);
    check("fresh_after_reset_latency", 256'(lat), 256'(3));
    @(posedge clk); #1;

    // Randomized traffic, sometimes back-to-back from DONE.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] f;
      kind_t      k;
      int         exp_lat;
      rand_cfg();
      f = 3'($urandom_range(1, 7));
      k = pick_kind(f[2], f[1]);
      if (k == K_WRITE)
        exp_lat = 3 + ((cur.aw_stall > cur.w_stall) ? cur.aw_stall : cur.w_stall) + cur.b_delay;
      else
        exp_lat = 3 + cur.ar_stall + cur.r_delay;
      start_req(f[2], f[1], f[0], $urandom(), rand_line());
      wait_done(lat);
      check("rand_latency", 256'(lat), 256'(exp_lat));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ace_master_port.md
ACE_MASTER_PORT -- requirements
Module: ace_master_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, line address width.
REQ-002 Parameter LINE_WIDTH, default 128, cache line width; all data transfers are single-beat full lines.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 read_req, write_req, invalid_req  input  1 each  requests from cache controller (ReadShared, WriteBack, CleanUnique).
REQ-006 req_addr  input  ADDR_WIDTH  line address from datapath; wb_data  input  LINE_WIDTH  dirty line for writeback.
REQ-007 ace_ready  output  1  one-cycle completion pulse to cache controller.
REQ-008 fill_data  output  LINE_WIDTH, fill_shared  output  1, resp_err  output  1  captured read data / IsShared / error flag.
REQ-009 AR: araddr  output  ADDR_WIDTH; arsnoop  output  4; arvalid  output  1; arready  input  1.
REQ-010 R: rdata  input  LINE_WIDTH; rresp  input  4; rvalid  input  1; rready  output  1.
REQ-011 AW: awaddr  output  ADDR_WIDTH; awsnoop  output  3; awvalid  output  1; awready  input  1.
REQ-012 W: wdata  output  LINE_WIDTH; wvalid  output  1; wready  input  1.
REQ-013 B: bresp  input  2; bvalid  input  1; bready  output  1; rack, wack  output  1 each  ACE acknowledges.

Function
REQ-014 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE.
REQ-015 Requests SHALL be sampled only in IDLE and DONE; priority write_req > invalid_req > read_req; lower-priority simultaneous requests dropped; requests in other states ignored (held read_req is legal).
REQ-016 On accept: req_addr latched into araddr/awaddr, wb_data into wdata; read -> arsnoop 4'b0001, invalidate -> arsnoop 4'b1011, both to RD_ADDR; write -> awsnoop 3'b011, to WR_ADDR_DATA.
REQ-017 RD_ADDR: arvalid=1, held with stable araddr/arsnoop until arvalid&arready; then RD_DATA.
REQ-018 RD_DATA: rready=1; on rvalid: read -> rdata into fill_data, rresp[3] into fill_shared; invalidate -> fill_data unchanged; resp_err=rresp[1]; to DONE.
REQ-019 WR_ADDR_DATA: awvalid and wvalid asserted together; each drops after its own handshake (aw_done/w_done flags); either order or same cycle; to WR_RESP when both done.
REQ-020 WR_RESP: bready=1; on bvalid: resp_err=bresp[1]; to DONE.
REQ-021 DONE: exactly one cycle; ace_ready=1; rack=1 if read/invalidate, wack=1 if write; new request accepted here as in IDLE, else to IDLE.
REQ-022 No valid SHALL depend combinationally on its ready; valid never deasserted before handshake.
REQ-023 fill_data, fill_shared, resp_err hold until next update; valid to consumer during ace_ready cycle.
REQ-024 Latency with ready/valid always high: request cycle N -> arvalid N+1, R handshake N+2, ace_ready N+3; write identical with AW/W at N+1, B at N+2.
REQ-025 rvalid/bvalid outside RD_DATA/WR_RESP SHALL be ignored (rready/bready low).

Reset
REQ-026 reset low SHALL force IDLE immediately; arvalid, awvalid, wvalid, rready, bready, ace_ready, rack, wack, resp_err, fill_shared =0; fill_data, araddr, awaddr, wdata, arsnoop, awsnoop =0; aw_done/w_done cleared.
REQ-027 Reset mid-transaction SHALL abandon it without ace_ready; first request after release starts fresh from IDLE.

Verification
REQ-028 read_req, req_addr=0x1000, arready=1, rvalid at N+2 rdata=0xA5..A5 rresp=4'b1000 -> arsnoop=1, ace_ready/rack at N+3, fill_data=0xA5..A5, fill_shared=1, resp_err=0.
REQ-029 write_req, wb_data=0x1234, awready low 3 cycles, wready=1 -> W handshake N+1, AW N+4, bready N+5, bvalid N+5 -> ace_ready/wack N+6; awvalid stable throughout.
REQ-030 write_req and read_req same cycle -> write only; held read_req during and after the write's DONE cycle starts a read in DONE (arvalid next cycle).
REQ-031 invalid_req, rresp=4'b0010 -> arsnoop=4'b1011, fill_data unchanged, resp_err=1 with ace_ready.
REQ-032 reset asserted in RD_DATA with arvalid done -> all outputs 0 same cycle; no ace_ready; later rvalid ignored until new request.
REQ-033 bvalid pulse while IDLE -> no bready, no ace_ready, state unchanged.
